// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_op_sequencer
// Brief    : Multi-cycle function-code sequencer for the ALU/HiLo datapath.
//            Optional abort input enabled by defining ALU_SEQ_ABORT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module alu_op_sequencer #(
    parameter int MUL_CYCLES = 32,
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [5:0] req_funct,
    output logic [5:0] dp_signal,
    output logic       mul_start,
    output logic       div_start,
    output logic       hilo_we,
    output logic       resp_valid,
    input  logic       resp_ready,
    output logic [5:0] resp_funct,
    output logic       resp_err,
`ifdef ALU_SEQ_ABORT_EN
    output logic       busy,
    input  logic       abort
`else
    output logic       busy
`endif
);

    localparam logic [5:0] c_AND   = 6'd36;
    localparam logic [5:0] c_OR    = 6'd37;
    localparam logic [5:0] c_ADD   = 6'd32;
    localparam logic [5:0] c_SUB   = 6'd34;
    localparam logic [5:0] c_SLT   = 6'd42;
    localparam logic [5:0] c_SRL   = 6'd2;
    localparam logic [5:0] c_MULTU = 6'd25;
    localparam logic [5:0] c_DIVU  = 6'd27;
    localparam logic [5:0] c_MFHI  = 6'd16;
    localparam logic [5:0] c_MFLO  = 6'd18;

    localparam logic [CNT_W-1:0] c_MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_EXEC  = 3'd1,
        S_LONG  = 3'd2,
        S_WRITE = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t           r_state_q, w_state_d;
    logic [5:0]       r_funct_q, w_funct_d;
    logic             r_err_q, w_err_d;
    logic [CNT_W-1:0] r_cnt_q, w_cnt_d;

    logic       r_req_ready_q, w_req_ready_d;
    logic [5:0] r_dp_signal_q, w_dp_signal_d;
    logic       r_mul_start_q, w_mul_start_d;
    logic       r_div_start_q, w_div_start_d;
    logic       r_hilo_we_q, w_hilo_we_d;
    logic       r_resp_valid_q, w_resp_valid_d;
    logic [5:0] r_resp_funct_q, w_resp_funct_d;
    logic       r_resp_err_q, w_resp_err_d;
    logic       r_busy_q, w_busy_d;
    logic       w_abort;

`ifdef ALU_SEQ_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    function automatic logic is_single(input logic [5:0] f);
        case (f)
            c_AND, c_OR, c_ADD, c_SUB, c_SLT, c_SRL, c_MFHI, c_MFLO: is_single = 1'b1;
            default:                                                 is_single = 1'b0;
        endcase
    endfunction

    always_comb begin
        w_state_d = r_state_q;
        w_funct_d = r_funct_q;
        w_err_d   = r_err_q;
        w_cnt_d   = r_cnt_q;
        case (r_state_q)
            S_IDLE: begin
                if (req_valid) begin
                    w_funct_d = req_funct;
                    w_err_d   = 1'b0;
                    if (req_funct == c_MULTU) begin
                        w_state_d = S_LONG;
                        w_cnt_d   = c_MUL_LOAD;
                    end else if (req_funct == c_DIVU) begin
                        w_state_d = S_LONG;
                        w_cnt_d   = c_DIV_LOAD;
                    end else if (is_single(req_funct)) begin
                        w_state_d = S_EXEC;
                    end else begin
                        w_state_d = S_RESP;
                        w_err_d   = 1'b1;
                    end
                end
            end
            S_EXEC:  w_state_d = S_RESP;
            S_LONG: begin
                if (w_abort) begin
                    w_state_d = S_IDLE;
                end else if (r_cnt_q == '0) begin
                    w_state_d = S_WRITE;
                end else begin
                    w_cnt_d = r_cnt_q - 1'b1;
                end
            end
            S_WRITE: w_state_d = w_abort ? S_IDLE : S_RESP;
            S_RESP:  if (resp_ready) w_state_d = S_IDLE;
            default: w_state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so they register cleanly.
        w_req_ready_d  = (w_state_d == S_IDLE);
        w_busy_d       = (w_state_d != S_IDLE);
        w_dp_signal_d  = (w_state_d == S_EXEC || w_state_d == S_LONG || w_state_d == S_WRITE)
                         ? w_funct_d : 6'd0;
        w_mul_start_d  = (r_state_q == S_IDLE) && (w_state_d == S_LONG) && (w_funct_d == c_MULTU);
        w_div_start_d  = (r_state_q == S_IDLE) && (w_state_d == S_LONG) && (w_funct_d == c_DIVU);
        w_hilo_we_d    = (w_state_d == S_WRITE);
        w_resp_valid_d = (w_state_d == S_RESP);
        w_resp_funct_d = (w_state_d == S_RESP) ? w_funct_d : 6'd0;
        w_resp_err_d   = (w_state_d == S_RESP) && w_err_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q      <= S_IDLE;
            r_funct_q      <= 6'd0;
            r_err_q        <= 1'b0;
            r_cnt_q        <= '0;
            r_req_ready_q  <= 1'b1;
            r_dp_signal_q  <= 6'd0;
            r_mul_start_q  <= 1'b0;
            r_div_start_q  <= 1'b0;
            r_hilo_we_q    <= 1'b0;
            r_resp_valid_q <= 1'b0;
            r_resp_funct_q <= 6'd0;
            r_resp_err_q   <= 1'b0;
            r_busy_q       <= 1'b0;
        end else begin
            r_state_q      <= w_state_d;
            r_funct_q      <= w_funct_d;
            r_err_q        <= w_err_d;
            r_cnt_q        <= w_cnt_d;
            r_req_ready_q  <= w_req_ready_d;
            r_dp_signal_q  <= w_dp_signal_d;
            r_mul_start_q  <= w_mul_start_d;
            r_div_start_q  <= w_div_start_d;
            r_hilo_we_q    <= w_hilo_we_d;
            r_resp_valid_q <= w_resp_valid_d;
            r_resp_funct_q <= w_resp_funct_d;
            r_resp_err_q   <= w_resp_err_d;
            r_busy_q       <= w_busy_d;
        end
    end

    assign req_ready  = r_req_ready_q;
    assign dp_signal  = r_dp_signal_q;
    assign mul_start  = r_mul_start_q;
    assign div_start  = r_div_start_q;
    assign hilo_we    = r_hilo_we_q;
    assign resp_valid = r_resp_valid_q;
    assign resp_funct = r_resp_funct_q;
    assign resp_err   = r_resp_err_q;
    assign busy       = r_busy_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_op_sequencer
// Brief    : Directed bench for alu_op_sequencer (MUL_CYCLES=32, DIV_CYCLES=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_op_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [5:0] req_funct;
    logic [5:0] dp_signal;
    logic       mul_start;
    logic       div_start;
    logic       hilo_we;
    logic       resp_valid;
    logic       resp_ready;
    logic [5:0] resp_funct;
    logic       resp_err;
    logic       busy;
`ifdef ALU_SEQ_ABORT_EN
    logic       abort;
`endif

    int vectors     = 0;
    int miscompares = 0;
    int n_mul, n_div, n_hilo, n_resp, n_rdy;

    alu_op_sequencer #(.MUL_CYCLES(32), .DIV_CYCLES(4), .CNT_W(6)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_funct  (req_funct),
        .dp_signal  (dp_signal),
        .mul_start  (mul_start),
        .div_start  (div_start),
        .hilo_we    (hilo_we),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_funct (resp_funct),
        .resp_err   (resp_err),
`ifdef ALU_SEQ_ABORT_EN
        .busy       (busy),
        .abort      (abort)
`else
        .busy       (busy)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        n_mul = 0; n_div = 0; n_hilo = 0; n_resp = 0; n_rdy = 0;
    endtask

    task automatic tally();
        n_mul  += int'(mul_start);
        n_div  += int'(div_start);
        n_hilo += int'(hilo_we);
        n_resp += int'(resp_valid);
        n_rdy  += int'(req_ready);
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_funct = 6'd0; resp_ready = 1'b0;
`ifdef ALU_SEQ_ABORT_EN
        abort = 1'b0;
`endif
        step(); step();
        check("rst_req_ready", req_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_dp_signal", dp_signal, 0);
        reset = 1'b0;

        // ADD, response held under back-pressure, pending request waits
        req_valid = 1'b1; req_funct = 6'd32;
        step();
        check("add_dp", dp_signal, 32);
        check("add_busy", busy, 1);
        check("add_req_ready", req_ready, 0);
        req_valid = 1'b0;
        step();
        check("add_resp_valid", resp_valid, 1);
        check("add_resp_funct", resp_funct, 32);
        check("add_resp_err", resp_err, 0);
        check("add_resp_dp", dp_signal, 0);
        req_valid = 1'b1; req_funct = 6'd37;
        for (int i = 0; i < 3; i++) begin
            step();
            check("add_hold_valid", resp_valid, 1);
            check("add_hold_funct", resp_funct, 32);
            check("add_hold_ready", req_ready, 0);
        end
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        check("add_done_valid", resp_valid, 0);
        check("add_done_idle", req_ready, 1);
        step();
        check("or_dp", dp_signal, 37);
        req_valid = 1'b0;
        step();
        check("or_resp_funct", resp_funct, 37);
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;

        // MULTU, 32 LONG cycles
        req_valid = 1'b1; req_funct = 6'd25;
        step();
        req_valid = 1'b0;
        check("mul_start_t1", mul_start, 1);
        check("mul_div_start_t1", div_start, 0);
        check("mul_dp_t1", dp_signal, 25);
        clear_counts();
        for (int k = 2; k <= 32; k++) begin
            step();
            tally();
            check("mul_dp_long", dp_signal, 25);
        end
        check("mul_extra_start", n_mul + n_div, 0);
        check("mul_early_hilo", n_hilo, 0);
        check("mul_ready_busy", n_rdy, 0);
        step();
        check("mul_hilo_t33", hilo_we, 1);
        check("mul_resp_t33", resp_valid, 0);
        step();
        check("mul_hilo_t34", hilo_we, 0);
        check("mul_resp_t34", resp_valid, 1);
        check("mul_resp_funct", resp_funct, 25);
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;

        // MFHI after HiLo written
        req_valid = 1'b1; req_funct = 6'd16;
        step();
        req_valid = 1'b0;
        check("mfhi_dp", dp_signal, 16);
        step();
        check("mfhi_dp_after", dp_signal, 0);
        check("mfhi_resp_funct", resp_funct, 16);
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;

        // DIVU, 4 LONG cycles
        req_valid = 1'b1; req_funct = 6'd27;
        step();
        req_valid = 1'b0;
        check("div_start_t1", div_start, 1);
        check("div_mul_t1", mul_start, 0);
        clear_counts();
        for (int k = 2; k <= 4; k++) begin
            step();
            tally();
        end
        check("div_extra_start", n_mul + n_div, 0);
        check("div_early_hilo", n_hilo, 0);
        step();
        check("div_hilo_t5", hilo_we, 1);
        check("div_mul_t5", mul_start, 0);
        step();
        check("div_resp_t6", resp_valid, 1);
        check("div_resp_funct", resp_funct, 27);
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;

        // Illegal code goes straight to RESP with an error
        req_valid = 1'b1; req_funct = 6'd63;
        step();
        req_valid = 1'b0;
        check("ill_resp_valid", resp_valid, 1);
        check("ill_resp_err", resp_err, 1);
        check("ill_resp_funct", resp_funct, 63);
        check("ill_pulses", {29'd0, mul_start, div_start, hilo_we}, 0);
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        check("ill_done", req_ready, 1);

        // Reset mid-LONG
        req_valid = 1'b1; req_funct = 6'd25;
        step();
        req_valid = 1'b0;
        for (int k = 2; k <= 10; k++) step();
        check("rstlong_busy_t10", busy, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rstlong_idle", req_ready, 1);
        check("rstlong_busy", busy, 0);
        clear_counts();
        for (int k = 0; k < 40; k++) begin
            step();
            tally();
        end
        check("rstlong_no_pulse", n_mul + n_div + n_hilo + n_resp, 0);

`ifdef ALU_SEQ_ABORT_EN
        req_valid = 1'b1; req_funct = 6'd25;
        step();
        req_valid = 1'b0;
        for (int k = 2; k <= 10; k++) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_idle", req_ready, 1);
        check("abort_busy", busy, 0);
        clear_counts();
        for (int k = 0; k < 40; k++) begin
            step();
            tally();
        end
        check("abort_no_pulse", n_mul + n_div + n_hilo + n_resp, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Multi-cycle sequencer in front of the shared ALU/Shifter/Multiplier/HiLo datapath.
- Accepts one function-code request at a time over a valid/ready handshake.
- Drives the 6-bit function code into the datapath.
- Times the long MULTU/DIVU operations and strobes the HiLo write.
- Returns a completion response with a valid/ready handshake.

Parameters:
MUL_CYCLES, 32, cycles the LONG state is held for MULTU (>=1)
DIV_CYCLES, 32, cycles the LONG state is held for DIVU (>=1)
CNT_W, 6, width of the long-operation down-counter; must hold max(MUL_CYCLES, DIV_CYCLES)-1

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  sequencer can accept a request
req_funct  input  6  function code: AND 36, OR 37, ADD 32, SUB 34, SLT 42, SRL 2, MULTU 25, DIVU 27, MFHI 16, MFLO 18
dp_signal  output  6  function code presented to the datapath
mul_start  output  1  one-cycle pulse starting the multiplier
div_start  output  1  one-cycle pulse starting the divider
hilo_we  output  1  one-cycle HiLo write strobe
resp_valid  output  1  completion available
resp_ready  input  1  consumer takes the completion
resp_funct  output  6  function code of the completed request
resp_err  output  1  completed request carried an illegal code
busy  output  1  high in every state except IDLE

Behaviour:
Clock and reset:
- One clock, clk. Reset is synchronous and active-high; the port is named reset.
- On reset: state=IDLE, counter=0, latched funct=0.
- All outputs 0 after reset except req_ready=1.

States: IDLE, EXEC, LONG, WRITE, RESP.
- IDLE
  - req_ready=1, dp_signal=0.
  - Accept on req_valid&&req_ready: latch req_funct and an illegal flag.
  - Legal single-cycle codes (AND, OR, ADD, SUB, SLT, SRL, MFHI, MFLO) -> EXEC.
  - MULTU or DIVU -> LONG; load counter with MUL_CYCLES-1 or DIV_CYCLES-1.
  - Illegal code -> RESP directly, with resp_err=1.
- EXEC
  - dp_signal = latched funct for exactly one cycle; datapath result is sampled this cycle.
  - -> RESP.
- LONG
  - dp_signal = latched funct throughout.
  - mul_start/div_start high only in the first LONG cycle, chosen by opcode.
  - Counter decrements each cycle. When counter==0 -> WRITE.
  - LONG lasts exactly MUL_CYCLES or DIV_CYCLES cycles.
- WRITE
  - dp_signal held; hilo_we=1 for one cycle.
  - -> RESP.
- RESP
  - resp_valid=1; resp_funct and resp_err stable and held.
  - dp_signal=0.
  - On resp_ready -> IDLE in the same cycle.

Latency (request accepted at edge T):
- Single-cycle op: EXEC in cycle T+1, resp_valid from T+2.
- Long op: start pulse at T+1, hilo_we at T+N+1, resp_valid from T+N+2, where N is the relevant *_CYCLES.

Boundary and hazard rules:
- req_ready is 0 in all states but IDLE. A request presented while busy is not accepted and must stay pending, unchanged.
- No overlap: MFHI/MFLO is only accepted after a prior MULTU/DIVU has written HiLo, so there is no read-before-write hazard.
- resp_ready while resp_valid=0 is ignored.
- Back-to-back throughput is at most one request per 3 cycles, since an IDLE cycle is required.
- Reset in any state, including mid-LONG, returns to IDLE next edge with no start, hilo_we or resp pulse.
- Illegal codes never pulse mul_start, div_start or hilo_we.

Optional Feature:
ALU_SEQ_ABORT_EN
- Defined:
  - Adds input port abort (1 bit).
  - abort=1 in LONG or WRITE -> IDLE next edge.
  - hilo_we is suppressed from that edge on, and no response is produced.
  - abort in IDLE, EXEC or RESP is ignored.
- Undefined: the port is absent and long operations always run to completion.

Test Plan:
- Reset: hold reset 2 cycles -> req_ready=1, busy=0, resp_valid=0, dp_signal=0.
- ADD: req_funct=32 accepted at T -> dp_signal=32 at T+1; resp_valid=1 and resp_funct=32 at T+2; hold resp_ready=0 for 3 cycles -> response stays stable; resp_ready=1 -> IDLE.
- MULTU with MUL_CYCLES=32: funct=25 at T -> mul_start pulse at T+1 only; hilo_we at T+33; resp at T+34; req_ready=0 throughout; follow with MFHI (16) -> dp_signal=16 for 1 cycle.
- DIVU with DIV_CYCLES=4: funct=27 -> div_start once, hilo_we at T+5, mul_start never asserted.
- Illegal funct=63 -> resp_valid at T+1 with resp_err=1; no start or hilo_we pulses.
- Reset asserted mid-LONG (cycle T+10 of MULTU) -> IDLE next edge, no hilo_we, no resp. With ALU_SEQ_ABORT_EN, the same check using abort instead of reset.
